// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MMIO load-store unit.
// Op decode, byte enables, store lane replication, load extend.
package lsu_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b10,
    BYTE = 2'b11
  } lsu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } lsu_state_e;

  localparam logic [15:0] TAG_DMEM = 16'h0000;
  localparam logic [15:0] TAG_IO   = 16'h1000;
  localparam logic [15:0] TAG_SW   = 16'h1001;

  // Raw op codes 00 and 01 both mean word.
  function automatic lsu_op_e to_op(
    input logic [1:0] op
  );
    if (!op[1]) return WORD;
    return op[0] ? BYTE : HALF;
  endfunction

  function automatic logic misalign(
    input lsu_op_e    op,
    input logic [1:0] off
  );
    logic m;
    unique case (op)
      WORD:    m = |off;
      HALF:    m = off[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(
    input lsu_op_e    op,
    input logic [1:0] off
  );
    logic [3:0] be;
    unique case (op)
      WORD:    be = 4'b1111;
      HALF:    be = off[1] ? 4'b1100 : 4'b0011;
      BYTE:    be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] st_rep(
    input lsu_op_e     op,
    input logic [31:0] d
  );
    logic [31:0] r;
    unique case (op)
      HALF:    r = {2{d[15:0]}};
      BYTE:    r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_extend(
    input logic [31:0] w,
    input lsu_op_e     op,
    input logic [1:0]  off,
    input logic        un
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    unique case (op)
      HALF:    r = {{16{~un & h[15]}}, h};
      BYTE:    r = {{24{~un & b[7]}}, b};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Single-port data RAM with byte-enable write
// and registered read (read-before-write).
module lsu_dmem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load-store unit for data RAM, output registers and switches.
// Two-state handshake: accept in IDLE, respond in RESP.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int          DMEM_DEPTH = 512,
  parameter int          IO_NUM     = 8,
  parameter int          SW_WIDTH   = 32,
  parameter logic [15:0] DMEM_BASE  = TAG_DMEM,
  parameter logic [15:0] IO_BASE    = TAG_IO,
  parameter logic [15:0] SW_BASE    = TAG_SW
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  output logic                 o_ready,
  input  logic [31:0]          i_lsu_addr,
  input  logic                 i_lsu_wren,
  input  logic [31:0]          i_st_data,
  input  logic [1:0]           i_lsu_op,
  input  logic                 i_ld_un,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_ld_data,
  output logic                 o_err,
  output logic [IO_NUM*32-1:0] o_io_out,
  input  logic [SW_WIDTH-1:0]  i_io_sw
);

  localparam int AW =
    (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  lsu_state_e r_state, w_next;

  logic          r_err, r_wren, r_un, r_from_dm;
  lsu_op_e       r_op;
  logic [1:0]    r_off;
  logic [31:0]   r_rword;
  logic [31:0]   r_io [IO_NUM];
  logic [SW_WIDTH-1:0] r_sw_s1, r_sw_s2;

  logic [15:0]   w_tag;
  logic [13:0]   w_idx;
  logic [3:0]    w_ch;
  logic [1:0]    w_off;
  lsu_op_e       w_op;
  logic          w_is_dm, w_is_io, w_is_sw;
  logic          w_idx_ok, w_ch_ok, w_err;
  logic          w_acc, w_ok, w_resp;
  logic [3:0]    w_be, w_dm_we;
  logic          w_dm_en;
  logic [31:0]   w_wd, w_dm_q, w_io_rd;
  logic [31:0]   w_sw_ext, w_word;

  assign w_tag = i_lsu_addr[31:16];
  assign w_idx = i_lsu_addr[15:2];
  assign w_ch  = i_lsu_addr[15:12];
  assign w_off = i_lsu_addr[1:0];
  assign w_op  = to_op(i_lsu_op);

  assign w_is_dm  = (w_tag == DMEM_BASE);
  assign w_is_io  = (w_tag == IO_BASE);
  assign w_is_sw  = (w_tag == SW_BASE);
  assign w_idx_ok = 32'(w_idx) < DMEM_DEPTH;
  assign w_ch_ok  = 32'(w_ch) < IO_NUM;

  assign w_err = misalign(w_op, w_off) ||
    !((w_is_dm && w_idx_ok) ||
      (w_is_io && w_ch_ok) ||
      (w_is_sw && !i_lsu_wren));

  assign o_ready = (r_state == IDLE) && i_reset;
  assign w_acc   = i_req && o_ready;
  assign w_ok    = w_acc && !w_err;

  assign w_be    = byte_en(w_op, w_off);
  assign w_wd    = st_rep(w_op, i_st_data);
  assign w_dm_en = w_ok && w_is_dm;
  assign w_dm_we = (w_dm_en && i_lsu_wren) ? w_be : 4'b0000;

  lsu_dmem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (AW)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_en    (w_dm_en),
    .i_we    (w_dm_we),
    .i_addr  (i_lsu_addr[AW+1:2]),
    .i_wdata (w_wd),
    .o_rdata (w_dm_q)
  );

  always_comb begin
    w_sw_ext = '0;
    w_sw_ext[SW_WIDTH-1:0] = r_sw_s2;
  end

  always_comb begin
    w_io_rd = '0;
    for (int k = 0; k < IO_NUM; k++) begin
      if (w_ch == 4'(k)) w_io_rd = r_io[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_err     <= 1'b0;
      r_wren    <= 1'b0;
      r_un      <= 1'b0;
      r_from_dm <= 1'b0;
      r_op      <= WORD;
      r_off     <= 2'b00;
      r_rword   <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      for (int k = 0; k < IO_NUM; k++) r_io[k] <= '0;
    end else begin
      r_sw_s1 <= i_io_sw;
      r_sw_s2 <= r_sw_s1;
      if (w_acc) begin
        r_err     <= w_err;
        r_wren    <= i_lsu_wren;
        r_un      <= i_ld_un;
        r_op      <= w_op;
        r_off     <= w_off;
        r_from_dm <= w_is_dm;
        r_rword   <= w_is_sw ? w_sw_ext : w_io_rd;
      end
      if (w_ok && w_is_io && i_lsu_wren) begin
        for (int k = 0; k < IO_NUM; k++) begin
          for (int b = 0; b < 4; b++) begin
            if (w_ch == 4'(k) && w_be[b])
              r_io[k][8*b +: 8] <= w_wd[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < IO_NUM; k++) begin : g_io
    assign o_io_out[32*k +: 32] = r_io[k];
  end

  // Responses vanish as soon as reset is asserted.
  assign w_resp      = (r_state == RESP) && i_reset;
  assign w_word      = r_from_dm ? w_dm_q : r_rword;
  assign o_rsp_valid = w_resp;
  assign o_err       = w_resp && r_err;
  assign o_ld_data   = (w_resp && !r_err && !r_wren)
    ? ld_extend(w_word, r_op, r_off, r_un) : '0;

endmodule

// File: tb/tb_lsu_mmio.sv
// Randomised scoreboard bench for lsu_mmio against
// a byte-level reference model of memory, IO and switches.
module tb_lsu_mmio;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_req = 1'b0;
  logic         o_ready;
  logic [31:0]  i_lsu_addr = '0;
  logic         i_lsu_wren = 1'b0;
  logic [31:0]  i_st_data = '0;
  logic [1:0]   i_lsu_op = '0;
  logic         i_ld_un = 1'b0;
  logic         o_rsp_valid;
  logic [31:0]  o_ld_data;
  logic         o_err;
  logic [255:0] o_io_out;
  logic [31:0]  i_io_sw = '0;

  lsu_mmio dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req       (i_req),
    .o_ready     (o_ready),
    .i_lsu_addr  (i_lsu_addr),
    .i_lsu_wren  (i_lsu_wren),
    .i_st_data   (i_st_data),
    .i_lsu_op    (i_lsu_op),
    .i_ld_un     (i_ld_un),
    .o_rsp_valid (o_rsp_valid),
    .o_ld_data   (o_ld_data),
    .o_err       (o_err),
    .o_io_out    (o_io_out),
    .i_io_sw     (i_io_sw)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0]  m_dm [512];
  logic [255:0] m_io = '0;
  logic [31:0]  m_sw = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] a,
                       input logic w,
                       input logic [31:0] d,
                       input logic [1:0] op,
                       input logic un);
    exp_t e;
    int tag, nb, off, idx, ch;
    logic ok;
    logic [31:0] word, mask, v;
    tag = int'(a >> 16);
    off = int'(a & 3);
    nb  = op[1] ? (op[0] ? 1 : 2) : 4;
    idx = int'((a >> 2) & 32'h3FFF);
    ch  = int'((a >> 12) & 32'hF);
    ok  = (off % nb) == 0;
    if (tag == 16'h0000)      ok = ok && idx < 512;
    else if (tag == 16'h1000) ok = ok && ch < 8;
    else if (tag == 16'h1001) ok = ok && !w;
    else                      ok = 1'b0;
    e.cyc = cyc + 1;
    e.err = !ok;
    e.data = 0;
    if (ok && w) begin
      for (int i = 0; i < nb; i++) begin
        if (tag == 16'h0000)
          m_dm[idx][8*(off+i) +: 8] = d[8*i +: 8];
        else
          m_io[32*ch + 8*(off+i) +: 8] = d[8*i +: 8];
      end
    end else if (ok) begin
      if (tag == 16'h0000)      word = m_dm[idx];
      else if (tag == 16'h1000) word = m_io[32*ch +: 32];
      else                      word = m_sw;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 1);
      v = (word >> (8*off)) & mask;
      if (!un && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.data = v;
    end
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic w,
                       input logic [31:0] d,
                       input logic [1:0] op,
                       input logic un);
    int guard = 0;
    i_lsu_addr = a;
    i_lsu_wren = w;
    i_st_data  = d;
    i_lsu_op   = op;
    i_ld_un    = un;
    i_req      = 1'b1;
    while (!o_ready && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 0, 1);
      i_req = 1'b0;
      return;
    end
    model(a, w, d, op, un);
    @(posedge i_clk); #1;
    i_req      = 1'b0;
    i_lsu_addr = $urandom;
    i_st_data  = $urandom;
    i_lsu_wren = 1'($urandom);
    @(posedge i_clk); #1;
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_latency", cyc, e.cyc);
        chk("rsp_err", o_err, e.err);
        chk("rsp_data", o_ld_data, e.data);
        chk("io_out", o_io_out, m_io);
      end
    end else if (q.size() > 0 && cyc > q[0].cyc) begin
      e = q.pop_front();
      chk("missing_rsp", 0, 1);
    end
  end

  initial begin
    logic [31:0] a;
    logic [5:0]  pat;
    int          nacc, r;
    logic [15:0] bad_tag [4];
    bad_tag[0] = 16'h2000;
    bad_tag[1] = 16'h0001;
    bad_tag[2] = 16'hFFFF;
    bad_tag[3] = 16'h1002;
    for (int i = 0; i < 512; i++) m_dm[i] = '0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_rsp_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ld_data", o_ld_data, 0);
    chk("rst_io", o_io_out, 0);
    i_reset = 1'b1;
    #1;
    chk("ready_after_rst", o_ready, 1);

    for (int i = 0; i < 16; i++)
      issue(32'(i * 4), 1, 0, 2'b00, 0);

    issue(32'h10, 1, 32'h8000_00F0, 2'b00, 0);
    issue(32'h10, 0, 0, 2'b11, 0);
    issue(32'h10, 0, 0, 2'b11, 1);

    issue(32'h10, 1, 32'h1111_2222, 2'b00, 0);
    issue(32'h12, 1, 32'h0000_BEEF, 2'b10, 0);
    issue(32'h10, 0, 0, 2'b00, 0);
    issue(32'h12, 0, 0, 2'b10, 0);

    issue(32'h0000_0002, 0, 0, 2'b00, 0);
    issue(32'h1000_0001, 1, 32'h1234, 2'b10, 0);
    issue(32'h2000_0000, 0, 0, 2'b00, 0);
    issue(32'h1001_0000, 1, 32'h55, 2'b00, 0);
    issue(32'h1000_9000, 1, 32'h66, 2'b00, 0);
    issue(32'h10, 0, 0, 2'b00, 1);

    issue(32'h1000_2000, 1, 32'h0000_7F3F, 2'b00, 0);
    chk("io_ch2", o_io_out[95:64], 32'h0000_7F3F);

    i_io_sw = 32'hA5;
    m_sw    = 32'hA5;
    repeat (3) @(posedge i_clk);
    #1;
    issue(32'h1001_0000, 0, 0, 2'b11, 1);

    i_lsu_addr = 32'h10;
    i_lsu_wren = 1'b0;
    i_lsu_op   = 2'b00;
    i_req      = 1'b1;
    nacc = 0;
    pat  = '0;
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = o_ready;
      if (o_ready) begin
        model(32'h10, 0, 0, 2'b00, 0);
        nacc++;
      end
      @(posedge i_clk); #1;
    end
    i_req = 1'b0;
    chk("hs_accepts", nacc, 3);
    chk("hs_ready_pat", pat, 6'b101010);
    @(posedge i_clk); #1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        i_io_sw = $urandom;
        m_sw    = i_io_sw;
        repeat (3) @(posedge i_clk);
        #1;
      end
      r = $urandom_range(0, 5);
      a = 32'($urandom_range(0, 3));
      case (r)
        0, 1: a = a | 32'($urandom_range(0, 15) << 2);
        2: a = a | 32'($urandom_range(512, 16383) << 2);
        3: a = a | {16'h1000, 4'($urandom_range(0, 9)),
                    12'($urandom)} & 32'hFFFF_FFFC;
        4: a = a | {16'h1001, 16'($urandom)} & 32'hFFFF_FFFC;
        default: a = a | {bad_tag[$urandom_range(0, 3)], 16'($urandom)};
      endcase
      issue(a, 1'($urandom), $urandom,
            2'($urandom), 1'($urandom));
    end

    issue(32'h1000_1000, 1, 32'hCAFE_F00D, 2'b00, 0);
    i_lsu_addr = 32'h10;
    i_lsu_wren = 1'b0;
    i_lsu_op   = 2'b00;
    i_req      = 1'b1;
    #0;
    model(32'h10, 0, 0, 2'b00, 0);
    @(posedge i_clk); #1;
    i_req   = 1'b0;
    i_reset = 1'b0;
    q.delete();
    m_io = '0;
    #1;
    chk("midrst_ready", o_ready, 0);
    chk("midrst_valid", o_rsp_valid, 0);
    @(posedge i_clk); #1;
    chk("midrst_io", o_io_out, 0);
    chk("midrst_ready2", o_ready, 0);
    chk("midrst_valid2", o_rsp_valid, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    #1;
    chk("rst_release_ready", o_ready, 1);
    issue(32'h10, 0, 0, 2'b00, 0);
    issue(32'h1000_1000, 0, 0, 2'b00, 0);

    repeat (4) @(posedge i_clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
# lsu_mmio

Parametrised load-store unit with a request/response handshake. It serves data-memory and memory-mapped I/O accesses for the core. Compared with the single-cycle LSU, it adds:
- configurable memory depth and I/O channel count;
- registered (one-cycle) reads;
- byte-enable stores;
- misaligned and unmapped access errors;
- switch-input synchronisation.

It sits between the core's execute stage and the on-chip data RAM and I/O registers.

## Interface
Parameters:
- DMEM_DEPTH, 512: data-memory depth in 32-bit words; must be a power of two, max 16384.
- IO_NUM, 8: number of 32-bit output registers, 1..16.
- SW_WIDTH, 32: switch input width, 1..32; zero-extended on read.
- DMEM_BASE, 16'h0000: addr[31:16] tag of data memory.
- IO_BASE, 16'h1000: addr[31:16] tag of output registers.
- SW_BASE, 16'h1001: addr[31:16] tag of switch input (read-only).

Ports:
- i_clk  in  1  global clock; all state changes on rising edge.
- i_reset  in  1  one clock; reset is synchronous and active-low.
- i_req  in  1  access request; sampled when o_ready=1.
- o_ready  out  1  unit can accept a request this cycle.
- i_lsu_addr  in  32  byte address.
- i_lsu_wren  in  1  1 = store, 0 = load.
- i_st_data  in  32  store data, right-aligned (byte/half in low bits).
- i_lsu_op  in  2  0x word, 10 half, 11 byte.
- i_ld_un  in  1  1 = zero-extend, 0 = sign-extend sub-word loads.
- o_rsp_valid  out  1  one-cycle response strobe (loads and stores).
- o_ld_data  out  32  load result, valid with o_rsp_valid.
- o_err  out  1  access faulted, valid with o_rsp_valid.
- o_io_out  out  IO_NUM*32  output registers, channel k at bits [32k+31:32k].
- i_io_sw  in  SW_WIDTH  asynchronous switch inputs.

## Operation
- FSM states are IDLE and RESP. o_ready = (state==IDLE) && i_reset.
- IDLE → RESP when i_req && o_ready. RESP → IDLE unconditionally after one cycle.
- Decode at acceptance:
  - DMEM region: word index addr[15:2] must be < DMEM_DEPTH.
  - IO region: channel addr[15:12] must be < IO_NUM; addr[11:2] ignored.
  - SW region: loads only.
- Error when:
  - the tag is unmapped;
  - the index is out of range;
  - the access is a store to SW;
  - the access is misaligned (word needs addr[1:0]=0, half needs addr[0]=0).
- On error: no state change, o_err=1, o_ld_data=0.
- Stores: byte enables come from op and addr[1:0]:
  - word 4'b1111;
  - half 4'b0011 or 4'b1100;
  - byte one-hot;
  - data is replicated to the selected lanes.
  - Only enabled bytes are written, at the acceptance edge.
  - o_ld_data=0 in the response.
- Loads: the lane is selected by addr[1:0], then sign- or zero-extended per i_ld_un. Word loads ignore i_ld_un.
- Switch reads return a 2-flop-synchronised copy of i_io_sw, zero-extended to 32 bits.
- DMEM contents are not initialised by reset. Simulation initial contents are all zero.

## Timing
- Reset values (i_reset=0 at an edge):
  - state=IDLE, o_rsp_valid=0, o_err=0, o_ld_data=0;
  - all o_io_out channels = 0;
  - switch synchroniser = 0;
  - o_ready=0 while i_reset=0.
- Latency: request accepted at edge N, so o_rsp_valid=1 during cycle N+1 only. Throughput is one access per 2 cycles.
- Store visibility: a load accepted at edge N+2 sees a store accepted at edge N. A store to IO is visible on o_io_out from cycle N+1.
- Switch latency: 2 cycles from an i_io_sw change to a readable value.
- i_req while o_ready=0 is ignored. Requests are not queued, and the requester must hold or re-issue.
- Reset mid-operation: a pending response is dropped (o_rsp_valid=0). A store accepted before the reset edge stays committed to DMEM, but IO registers clear.
- Address/op inputs are only sampled at the acceptance edge. Changes in RESP have no effect.

## Structure
- Package lsu_pkg holds:
  - typedef lsu_op_e (WORD, HALF, BYTE);
  - typedef lsu_state_e (IDLE, RESP);
  - region tag constants;
  - function byte_en(op, addr[1:0]) returning 4 bits;
  - function ld_extend(word, op, addr[1:0], un) returning 32 bits.
- Sub-module lsu_dmem: single-port synchronous RAM, DMEM_DEPTH×32, 4-bit byte-enable write, registered read.
- Decode, FSM, IO registers and synchroniser stay in lsu_mmio.

## Test plan
- Reset then byte stores: store word 32'h8000_00F0 to 0x0000_0010, then lb 0x10 and lbu 0x10.
  - Responses are 32'hFFFF_FFF0 and 32'h0000_00F0.
  - Each o_rsp_valid pulses exactly one cycle after acceptance.
- Half store: sh 16'hBEEF to 0x12 over word 32'h1111_2222 at 0x10, then lw 0x10 returns 32'hBEEF_2222. lh 0x12 returns 32'hFFFF_BEEF.
- Misaligned or unmapped access: each returns o_err=1, o_ld_data=0, and leaves memory/IO unchanged.
  - lw 0x0000_0002;
  - sh 0x1000_0001;
  - lw 0x2000_0000;
  - sw to 0x1001_0000;
  - with IO_NUM=8, sw to 0x1000_9000.
- IO and switches:
  - sw 32'h0000_7F3F to 0x1000_2000 makes o_io_out channel 2 = 32'h0000_7F3F in the next cycle.
  - Set i_io_sw=32'hA5; lbu 0x1001_0000 issued ≥2 cycles later returns 32'h0000_00A5.
- Handshake: hold i_req=1 for 6 cycles, which yields exactly 3 accepted accesses. o_ready alternates 1,0,1,0.
- Reset mid-operation: assert i_reset=0 in the RESP cycle of a load. No o_rsp_valid follows, o_io_out reads 0, and o_ready stays 0 until the first edge with i_reset=1.
